sdram_rw_ctrl: RTL and testbench



---
 rtl/sdram_pkg.sv | 57 +++++
 rtl/sdram_refresh_timer.sv | 40 ++++
 rtl/sdram_rw_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_sdram_rw_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg: shared definitions for the SDRAM read/write controller.
//   - SDRAM timing parameters, in iclk cycles
//   - 4-bit {CS_N, RAS_N, CAS_N, WE_N} command encodings
//   - host address field widths and positions
//   - controller state enum and wait-counter sizing
package sdram_pkg;

    localparam int unsigned T_RCD        = 2;
    localparam int unsigned CAS_LAT      = 2;   // must match the mode register (CL=2)
    localparam int unsigned T_RP         = 2;
    localparam int unsigned T_WRP        = 3;   // tWR + tRP after a write with auto-precharge
    localparam int unsigned T_RC         = 7;
    localparam int unsigned REF_INTERVAL = 390; // 7.8 us at 50 MHz

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_PALL = 4'b0010;
    localparam logic [3:0] CMD_REF  = 4'b0001;
    localparam logic [3:0] CMD_MRS  = 4'b0000;

    // Host address = {bank, row, col}
    localparam int unsigned BANK_W   = 2;
    localparam int unsigned ROW_W    = 13;
    localparam int unsigned COL_W    = 10;
    localparam int unsigned ADDR_W   = BANK_W + ROW_W + COL_W;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned COL_LSB  = 0;
    localparam int unsigned ROW_LSB  = COL_W;
    localparam int unsigned BANK_LSB = COL_W + ROW_W;
    localparam int unsigned AP_BIT   = 10;  // A10: auto-precharge / precharge-all

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned WAIT_MAX  = max_u(max_u(max_u(T_RCD, CAS_LAT), max_u(T_RP, T_WRP)),
                                              T_RC);
    localparam int unsigned WAIT_W    = $clog2(WAIT_MAX + 1);
    localparam int unsigned REF_CNT_W = $clog2(REF_INTERVAL);

    typedef enum logic [3:0] {
        StWaitInit,
        StIdle,
        StAct,
        StRcd,
        StRd,
        StCl,
        StCap,
        StWr,
        StPre,
        StWaitq,
        StRef
    } state_t;

endpackage

// File: rtl/sdram_refresh_timer.sv
// sdram_refresh_timer: periodic refresh request generator.
//   iclk      - system clock
//   ctr_reset - async reset, active-high
//   ienb      - counter runs while high (controller out of WAIT_INIT)
//   iack      - refresh being issued; clears the pending flag
//   opending  - a refresh is owed
// The counter runs 0..REF_INTERVAL-1 and sets opending on wrap. A wrap while already pending
// leaves the flag set; missed intervals are not queued.
module sdram_refresh_timer
    import sdram_pkg::*;
(
    input  logic iclk,
    input  logic ctr_reset,
    input  logic ienb,
    input  logic iack,
    output logic opending
);

    logic [REF_CNT_W-1:0] ref_cnt;
    logic                 wrap;

    assign wrap = ienb && (ref_cnt == REF_CNT_W'(REF_INTERVAL - 1));

    always_ff @(posedge iclk or posedge ctr_reset) begin
        if (ctr_reset) begin
            ref_cnt  <= '0;
            opending <= 1'b0;
        end else begin
            if (ienb) begin
                ref_cnt <= wrap ? '0 : ref_cnt + 1'b1;
            end
            if (wrap) begin
                opending <= 1'b1;
            end else if (iack) begin
                opending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sdram_rw_ctrl.sv
// sdram_rw_ctrl: single-word closed-page SDRAM read/write controller with auto refresh.
// Takes over the SDRAM pins once the init block reports done.
//   iclk, ctr_reset       - clock, async active-high reset
//   iinit_done            - init block finished; leave WAIT_INIT
//   ireq/iwe/iaddr/iwdata - access request, sampled when ireq && oready
//   oready                - can accept this cycle
//   odone/ordata          - 1-cycle completion pulse; read data valid with it
//   oenb                  - this block owns the pins (pins are Z otherwise)
//   DRAM_*                - SDRAM pins; DRAM_CLK = ~iclk
module sdram_rw_ctrl
    import sdram_pkg::*;
(
    input  logic              iclk,
    input  logic              ctr_reset,
    input  logic              iinit_done,
    input  logic              ireq,
    input  logic              iwe,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic [DATA_W-1:0] iwdata,
    output logic              oready,
    output logic              odone,
    output logic [DATA_W-1:0] ordata,
    output logic              oenb,
    output wire               DRAM_CLK,
    output wire               DRAM_CKE,
    output wire               DRAM_CS_N,
    output wire               DRAM_RAS_N,
    output wire               DRAM_CAS_N,
    output wire               DRAM_WE_N,
    output wire  [BANK_W-1:0] DRAM_BA,
    output wire  [ROW_W-1:0]  DRAM_ADDR,
    output wire               DRAM_UDQM,
    output wire               DRAM_LDQM,
    inout  wire  [DATA_W-1:0] DRAM_DQ
);

    state_t              state;
    logic [WAIT_W-1:0]   wcnt;
    logic [3:0]          cmd;
    logic [BANK_W-1:0]   ba;
    logic [ROW_W-1:0]    addr;
    logic [1:0]          dqm;
    logic                dq_oe;
    logic                req_we;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic                ref_pending;
    logic                ref_ack;

    assign oready  = (state == StIdle) && !ref_pending;
    assign ref_ack = (state == StIdle) && ref_pending;

    sdram_refresh_timer u_ref (
        .iclk     (iclk),
        .ctr_reset(ctr_reset),
        .ienb     (state != StWaitInit),
        .iack     (ref_ack),
        .opending (ref_pending)
    );

    // All pin registers describe the command driven in the cycle after the edge.
    always_ff @(posedge iclk or posedge ctr_reset) begin
        if (ctr_reset) begin
            state     <= StWaitInit;
            wcnt      <= '0;
            oenb      <= 1'b0;
            odone     <= 1'b0;
            ordata    <= '0;
            cmd       <= CMD_NOP;
            ba        <= '0;
            addr      <= '0;
            dqm       <= 2'b11;
            dq_oe     <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
        end else begin
            cmd   <= CMD_NOP;
            ba    <= '0;
            addr  <= '0;
            dqm   <= 2'b11;
            dq_oe <= 1'b0;
            odone <= 1'b0;
            unique case (state)
                StWaitInit: begin
                    if (iinit_done) begin
                        state <= StIdle;
                        oenb  <= 1'b1;
                    end
                end
                StIdle: begin
                    if (ref_pending) begin
                        state <= StRef;
                        cmd   <= CMD_REF;
                        wcnt  <= WAIT_W'(T_RC - 1);
                    end else if (ireq) begin
                        req_we    <= iwe;
                        req_addr  <= iaddr;
                        req_wdata <= iwdata;
                        state     <= StAct;
                        cmd       <= CMD_ACT;
                        ba        <= iaddr[BANK_LSB +: BANK_W];
                        addr      <= iaddr[ROW_LSB +: ROW_W];
                    end
                end
                StAct: begin
                    state <= StRcd;
                    wcnt  <= WAIT_W'(T_RCD - 2);
                end
                StRcd: begin
                    if (wcnt != '0) begin
                        wcnt <= wcnt - 1'b1;
                    end else begin
                        ba                 <= req_addr[BANK_LSB +: BANK_W];
                        addr[COL_W-1:0]    <= req_addr[COL_LSB +: COL_W];
                        addr[AP_BIT]       <= req_we;  // auto-precharge on writes only
                        dqm                <= 2'b00;
                        if (req_we) begin
                            state <= StWr;
                            cmd   <= CMD_WR;
                            dq_oe <= 1'b1;
                        end else begin
                            state <= StRd;
                            cmd   <= CMD_RD;
                        end
                    end
                end
                StRd: begin
                    state <= StCl;
                    dqm   <= 2'b00;
                    wcnt  <= WAIT_W'(CAS_LAT - 2);
                end
                StCl: begin
                    dqm <= 2'b00;
                    if (wcnt != '0) begin
                        wcnt <= wcnt - 1'b1;
                    end else begin
                        state <= StCap;
                    end
                end
                StCap: begin
                    // Precharge-all also truncates the remaining BL=8 burst.
                    ordata       <= DRAM_DQ;
                    odone        <= 1'b1;
                    cmd          <= CMD_PALL;
                    addr[AP_BIT] <= 1'b1;
                    state        <= StPre;
                end
                StPre: begin
                    state <= StWaitq;
                    wcnt  <= WAIT_W'(T_RP - 2);
                end
                StWr: begin
                    odone <= 1'b1;
                    state <= StWaitq;
                    wcnt  <= WAIT_W'(T_WRP - 1);
                end
                StWaitq, StRef: begin
                    if (wcnt != '0) begin
                        wcnt <= wcnt - 1'b1;
                    end else begin
                        state <= StIdle;
                    end
                end
                default: state <= StWaitInit;
            endcase
        end
    end

    assign DRAM_CLK   = oenb ? ~iclk : 1'bz;
    assign DRAM_CKE   = oenb ? 1'b1 : 1'bz;
    assign DRAM_CS_N  = oenb ? cmd[3] : 1'bz;
    assign DRAM_RAS_N = oenb ? cmd[2] : 1'bz;
    assign DRAM_CAS_N = oenb ? cmd[1] : 1'bz;
    assign DRAM_WE_N  = oenb ? cmd[0] : 1'bz;
    assign DRAM_BA    = oenb ? ba : {BANK_W{1'bz}};
    assign DRAM_ADDR  = oenb ? addr : {ROW_W{1'bz}};
    assign DRAM_UDQM  = oenb ? dqm[1] : 1'bz;
    assign DRAM_LDQM  = oenb ? dqm[0] : 1'bz;
    assign DRAM_DQ    = (oenb && dq_oe) ? req_wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sdram_rw_ctrl.sv
module tb_sdram_rw_ctrl;
    import sdram_pkg::*;

    logic        iclk = 1'b0;
    logic        ctr_reset = 1'b0;
    logic        iinit_done = 1'b0;
    logic        ireq = 1'b0;
    logic        iwe = 1'b0;
    logic [24:0] iaddr = '0;
    logic [15:0] iwdata = '0;
    logic        oready, odone, oenb;
    logic [15:0] ordata;
    wire         dram_clk, dram_cke, cs_n, ras_n, cas_n, we_n, udqm, ldqm;
    wire  [1:0]  dram_ba;
    wire  [12:0] dram_addr;
    wire  [15:0] dram_dq;

    logic        model_oe = 1'b0;
    logic [15:0] model_data = '0;
    assign dram_dq = model_oe ? model_data : 16'hzzzz;

    logic [3:0] pin_cmd;
    assign pin_cmd = {cs_n, ras_n, cas_n, we_n};

    sdram_rw_ctrl dut (
        .iclk      (iclk),
        .ctr_reset (ctr_reset),
        .iinit_done(iinit_done),
        .ireq      (ireq),
        .iwe       (iwe),
        .iaddr     (iaddr),
        .iwdata    (iwdata),
        .oready    (oready),
        .odone     (odone),
        .ordata    (ordata),
        .oenb      (oenb),
        .DRAM_CLK  (dram_clk),
        .DRAM_CKE  (dram_cke),
        .DRAM_CS_N (cs_n),
        .DRAM_RAS_N(ras_n),
        .DRAM_CAS_N(cas_n),
        .DRAM_WE_N (we_n),
        .DRAM_BA   (dram_ba),
        .DRAM_ADDR (dram_addr),
        .DRAM_UDQM (udqm),
        .DRAM_LDQM (ldqm),
        .DRAM_DQ   (dram_dq)
    );

    always #5 iclk = ~iclk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int tb_cnt = 0;
    int n_ref = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge iclk) cyc <= cyc + 1;

    // Reference refresh interval counter: runs while the controller is out of WAIT_INIT.
    always @(posedge iclk or posedge ctr_reset) begin
        if (ctr_reset) tb_cnt <= 0;
        else if (oenb) tb_cnt <= (tb_cnt == REF_INTERVAL - 1) ? 0 : tb_cnt + 1;
    end

    // Scoreboard: push on accept, pop on odone.
    typedef struct {
        logic        we;
        logic [15:0] exp;
        int          acc;
    } sb_t;
    sb_t         sb[$];
    logic [15:0] pend_exp = '0;

    always @(negedge iclk) begin
        sb_t e;
        if (ctr_reset) begin
            sb.delete();
        end else begin
            if (odone) begin
                if (sb.size() == 0) begin
                    chk("odone_unexpected", odone, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk(e.we ? "wr_latency" : "rd_latency", cyc - e.acc, e.we ? 4 : 6);
                    if (!e.we) chk("rd_data", ordata, e.exp);
                end
            end
            if (ireq && oready) sb.push_back('{iwe, pend_exp, cyc});
        end
    end

    // SDRAM model: samples commands on DRAM_CLK rise (iclk fall), CL=2, one word per read.
    logic [15:0] mem [logic [24:0]];
    logic [12:0] open_row [4];
    int          rd_cnt = 0;
    logic [15:0] rd_word = '0;
    int          last_ref = -1;

    always @(negedge iclk) begin
        logic [24:0] k;
        if (ctr_reset) begin
            model_oe <= 1'b0;
            rd_cnt   <= 0;
            last_ref <= -1;
        end else begin
            model_oe <= 1'b0;
            if (rd_cnt == 1) begin
                model_oe   <= 1'b1;
                model_data <= rd_word;
            end
            if (rd_cnt > 0) rd_cnt <= rd_cnt - 1;
            if (oenb) begin
                k = {dram_ba, open_row[dram_ba], dram_addr[9:0]};
                case (pin_cmd)
                    CMD_ACT: begin
                        open_row[dram_ba] <= dram_addr;
                        if (last_ref >= 0) chk("act_after_ref_trc", 32'(cyc - last_ref >= T_RC), 1);
                    end
                    CMD_WR: begin
                        if ({udqm, ldqm} == 2'b00) mem[k] = dram_dq;
                    end
                    CMD_RD: begin
                        rd_word <= mem.exists(k) ? mem[k] : 16'h0000;
                        rd_cnt  <= CAS_LAT;
                    end
                    CMD_REF: begin
                        if (last_ref >= 0)
                            chk("ref_interval", 32'(cyc - last_ref <= REF_INTERVAL + 8), 1);
                        last_ref <= cyc;
                        n_ref    <= n_ref + 1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Issue one request and hold ireq until accepted; returns 1 ns into the cycle after accept.
    task automatic do_access(input logic we, input logic [24:0] a, input logic [15:0] d,
                             input logic [15:0] exp);
        bit ok = 0;
        ireq     = 1'b1;
        iwe      = we;
        iaddr    = a;
        iwdata   = d;
        pend_exp = exp;
        for (int n = 0; n < 1000 && !ok; n++) begin
            @(negedge iclk);
            if (oready) ok = 1;
        end
        chk("accept", 32'(ok), 1);
        if (ok) begin
            @(posedge iclk);
            #1;
        end
        ireq = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge iclk);
        chk("drain", sb.size(), 0);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  bank;
        logic [12:0] row;
        logic [9:0]  col;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;
    vec_t vecs[7];

    localparam logic [24:0] ADDR_A = {2'b01, 13'h0123, 10'h045};

    initial begin
        int t0;
        int n_ref0;
        int done_cnt;
        int n;
        logic [24:0] a;
        logic [15:0] d;

        vecs[0] = '{1'b1, 2'd0, 13'h0000, 10'h000, 16'h1234, 16'h0000};
        vecs[1] = '{1'b1, 2'd3, 13'h1FFF, 10'h3FF, 16'hA5A5, 16'h0000};
        vecs[2] = '{1'b0, 2'd0, 13'h0000, 10'h000, 16'h0000, 16'h1234};
        vecs[3] = '{1'b0, 2'd3, 13'h1FFF, 10'h3FF, 16'h0000, 16'hA5A5};
        vecs[4] = '{1'b1, 2'd3, 13'h1FFF, 10'h3FE, 16'h5A5A, 16'h0000};
        vecs[5] = '{1'b0, 2'd3, 13'h1FFF, 10'h3FF, 16'h0000, 16'hA5A5};
        vecs[6] = '{1'b0, 2'd3, 13'h1FFF, 10'h3FE, 16'h0000, 16'h5A5A};

        // Reset and init handoff
        #1 ctr_reset = 1'b1;
        @(posedge iclk); #1;
        @(posedge iclk); #1;
        ctr_reset = 1'b0;
        @(negedge iclk);
        chk("rst_oenb", oenb, 0);
        chk("rst_oready", oready, 0);
        chk("rst_odone", odone, 0);
        chk("rst_ordata", ordata, 0);
        while (cyc < 5) begin @(posedge iclk); #1; end
        iinit_done = 1'b1;
        @(negedge iclk);
        chk("init_oenb_c5", oenb, 0);
        @(negedge iclk);
        chk("init_oenb_c6", oenb, 1);
        chk("init_oready", oready, 1);
        chk("init_cmd", pin_cmd, CMD_NOP);
        chk("init_dqm", {udqm, ldqm}, 2'b11);
        chk("init_cke", dram_cke, 1);
        chk("init_addr", dram_addr, 0);
        chk("init_ba", dram_ba, 0);

        // Write 0xBEEF, pin-level checks
        do_access(1'b1, ADDR_A, 16'hBEEF, 16'h0000);
        @(negedge iclk);
        chk("wr_c1_cmd", pin_cmd, CMD_ACT);
        chk("wr_c1_ba", dram_ba, 2'b01);
        chk("wr_c1_row", dram_addr, 13'h0123);
        @(negedge iclk);
        chk("wr_c2_cmd", pin_cmd, CMD_NOP);
        @(negedge iclk);
        chk("wr_c3_cmd", pin_cmd, CMD_WR);
        chk("wr_c3_addr", dram_addr, 13'h0445);
        chk("wr_c3_ba", dram_ba, 2'b01);
        chk("wr_c3_dq", dram_dq, 16'hBEEF);
        chk("wr_c3_dqm", {udqm, ldqm}, 2'b00);
        wait_drain();

        // Read it back, pin-level checks
        do_access(1'b0, ADDR_A, 16'h0000, 16'hBEEF);
        @(negedge iclk);
        chk("rd_c1_cmd", pin_cmd, CMD_ACT);
        @(negedge iclk);
        @(negedge iclk);
        chk("rd_c3_cmd", pin_cmd, CMD_RD);
        chk("rd_c3_addr", dram_addr, 13'h0045);
        chk("rd_c3_dqm", {udqm, ldqm}, 2'b00);
        @(negedge iclk);
        chk("rd_c4_dqm", {udqm, ldqm}, 2'b00);
        @(negedge iclk);
        chk("rd_c5_dqm", {udqm, ldqm}, 2'b00);
        @(negedge iclk);
        chk("rd_c6_cmd", pin_cmd, CMD_PALL);
        chk("rd_c6_a10", dram_addr, 13'h0400);
        chk("rd_c6_odone", odone, 1);
        @(negedge iclk);
        chk("rd_c7_oready", oready, 0);
        @(negedge iclk);
        chk("rd_c8_oready", oready, 1);
        wait_drain();

        // Table-driven accesses
        for (int i = 0; i < 7; i++) begin
            do_access(vecs[i].we, {vecs[i].bank, vecs[i].row, vecs[i].col}, vecs[i].wdata,
                      vecs[i].exp_rdata);
        end
        wait_drain();

        // Continuous requests for 2000 cycles
        t0 = cyc;
        n_ref0 = n_ref;
        for (int i = 0; cyc - t0 < 2000; i++) begin
            a = {i[1:0], 13'(i * 37), 10'(i * 3)};
            d = 16'(i * 16'h1357) ^ 16'hC3C3;
            do_access(1'b1, a, d, 16'h0000);
            do_access(1'b0, a, 16'h0000, d);
        end
        wait_drain();
        chk("stream_ref_count", 32'(n_ref - n_ref0 >= 2000 / (REF_INTERVAL + 8)), 1);

        // Refresh wrap on the same edge as an accept
        n = 0;
        do begin
            @(posedge iclk); #1;
            n++;
        end while (tb_cnt != REF_INTERVAL - 1 && n < 1000);
        chk("wrap_align", tb_cnt, REF_INTERVAL - 1);
        do_access(1'b0, ADDR_A, 16'h0000, 16'hBEEF);
        repeat (8) @(negedge iclk);
        chk("wrap_c8_oready", oready, 0);
        @(negedge iclk);
        chk("wrap_c9_cmd", pin_cmd, CMD_REF);
        wait_drain();

        // Reset during the CAS wait
        do_access(1'b0, ADDR_A, 16'h0000, 16'hBEEF);
        @(posedge iclk);
        @(posedge iclk);
        @(posedge iclk);
        #2;
        ctr_reset  = 1'b1;
        iinit_done = 1'b0;
        #1;
        chk("abort_oenb", oenb, 0);
        chk("abort_oready", oready, 0);
        @(posedge iclk); #1;
        chk("abort_odone", odone, 0);
        chk("abort_ordata", ordata, 0);
        @(posedge iclk); #1;
        ctr_reset = 1'b0;
        repeat (3) @(posedge iclk);
        #1 iinit_done = 1'b1;
        done_cnt = 0;
        repeat (20) begin
            @(negedge iclk);
            if (odone) done_cnt++;
        end
        chk("no_odone_after_reset", done_cnt, 0);
        chk("reinit_oenb", oenb, 1);
        do_access(1'b0, ADDR_A, 16'h0000, 16'hBEEF);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected end of test (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
